// File: rtl/ipsl_pcie_apb_arb_v1_0.sv
// ipsl_pcie_apb_arb_v1_0: round-robin arbiter sharing one APB config port between two masters,
// with a programmable access-phase timeout so a stalled slave cannot lock the bus.
module ipsl_pcie_apb_arb_v1_0 #(
    parameter int unsigned     TO_W      = 16,
    parameter logic [TO_W-1:0] TO_CYCLES = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_p_sel,
    input  logic [3:0]  i_m0_p_strb,
    input  logic [15:0] i_m0_p_addr,
    input  logic [31:0] i_m0_p_wdata,
    input  logic        i_m0_p_we,
    output logic        o_m0_p_rdy,
    output logic [31:0] o_m0_p_rdata,
    input  logic        i_m1_p_sel,
    input  logic [3:0]  i_m1_p_strb,
    input  logic [15:0] i_m1_p_addr,
    input  logic [31:0] i_m1_p_wdata,
    input  logic        i_m1_p_we,
    output logic        o_m1_p_rdy,
    output logic [31:0] o_m1_p_rdata,
    output logic        o_p_sel,
    output logic        o_p_ce,
    output logic        o_p_we,
    output logic [3:0]  o_p_strb,
    output logic [15:0] o_p_addr,
    output logic [31:0] o_p_wdata,
    input  logic        i_p_rdy,
    input  logic [31:0] i_p_rdata,
    output logic        o_timeout,
    output logic        o_grant
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_CYCLES - 1'b1;

    state_t          state_q, state_d;
    logic            grant_q, grant_d, last_q, last_d;
    logic            sel_q, sel_d, ce_q, ce_d, we_q, we_d;
    logic [3:0]      strb_q, strb_d;
    logic [15:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            rdy0_q, rdy0_d, rdy1_q, rdy1_d, to_q, to_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            win, abort;

    // On a tie the master that did not own the previous transfer wins.
    assign win   = (i_m0_p_sel && i_m1_p_sel) ? ~last_q : i_m1_p_sel;
    assign abort = (TO_CYCLES != '0) && (cnt_q == TO_LAST) && !i_p_rdy;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        sel_d    = sel_q;
        ce_d     = ce_q;
        we_d     = we_q;
        strb_d   = strb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rdy0_d   = 1'b0;
        rdy1_d   = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: if (i_m0_p_sel || i_m1_p_sel) begin
                state_d = SETUP;
                grant_d = win;
                last_d  = win;
                sel_d   = 1'b1;
                we_d    = win ? i_m1_p_we    : i_m0_p_we;
                strb_d  = win ? i_m1_p_strb  : i_m0_p_strb;
                addr_d  = win ? i_m1_p_addr  : i_m0_p_addr;
                wdata_d = win ? i_m1_p_wdata : i_m0_p_wdata;
            end
            SETUP: begin
                state_d = ACCESS;
                ce_d    = 1'b1;
                cnt_d   = '0;
            end
            ACCESS: if (i_p_rdy || abort) begin
                state_d  = DONE;
                sel_d    = 1'b0;
                ce_d     = 1'b0;
                we_d     = 1'b0;
                strb_d   = '0;
                addr_d   = '0;
                wdata_d  = '0;
                rdy0_d   = !grant_q;
                rdy1_d   = grant_q;
                to_d     = abort;
                rdata0_d = grant_q ? rdata0_q : (abort ? 32'h0 : i_p_rdata);
                rdata1_d = grant_q ? (abort ? 32'h0 : i_p_rdata) : rdata1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            ce_q     <= 1'b0;
            we_q     <= 1'b0;
            strb_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            ce_q     <= ce_d;
            we_q     <= we_d;
            strb_q   <= strb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rdy0_q   <= rdy0_d;
            rdy1_q   <= rdy1_d;
            to_q     <= to_d;
        end
    end

    assign o_p_sel      = sel_q;
    assign o_p_ce       = ce_q;
    assign o_p_we       = we_q;
    assign o_p_strb     = strb_q;
    assign o_p_addr     = addr_q;
    assign o_p_wdata    = wdata_q;
    assign o_m0_p_rdy   = rdy0_q;
    assign o_m1_p_rdy   = rdy1_q;
    assign o_m0_p_rdata = rdata0_q;
    assign o_m1_p_rdata = rdata1_q;
    assign o_timeout    = to_q;
    assign o_grant      = grant_q;
endmodule

// File: tb/tb_ipsl_pcie_apb_arb_v1_0.sv
// tb_ipsl_pcie_apb_arb_v1_0: scoreboard bench; dut_a has an 8-cycle timeout, dut_b has the timeout disabled.
module tb_ipsl_pcie_apb_arb_v1_0;
    typedef struct {
        bit          who;
        logic [31:0] rdata;
        bit          to;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m0_sel = 1'b0, m1_sel = 1'b0, m0_we = 1'b0, m1_we = 1'b0, p_rdy = 1'b0;
    logic [3:0]  m0_strb = '0, m1_strb = '0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0, p_rdata = '0;

    logic        a_rdy0, a_rdy1, a_sel, a_ce, a_we, a_to, a_gr;
    logic [3:0]  a_strb;
    logic [15:0] a_addr;
    logic [31:0] a_wdata, a_rd0, a_rd1;
    logic        b_rdy0, b_rdy1, b_sel, b_ce, b_we, b_to, b_gr;
    logic [3:0]  b_strb;
    logic [15:0] b_addr;
    logic [31:0] b_wdata, b_rd0, b_rd1;

    logic        s_rdy0, s_rdy1, s_sel, s_ce, s_to, s_gr;
    logic [31:0] s_rd0, s_rd1;
    logic [122:0] a_all, b_all;

    int          n_vec = 0, n_err = 0, cyc = 0, wait_n = 0, dly = 0;
    bit          use_b = 1'b0, hold = 1'b0;
    logic [31:0] rd_val = '0;

    always #5 clk = ~clk;

    ipsl_pcie_apb_arb_v1_0 #(.TO_W(16), .TO_CYCLES(16'd8)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_p_sel(m0_sel), .i_m0_p_strb(m0_strb), .i_m0_p_addr(m0_addr), .i_m0_p_wdata(m0_wdata), .i_m0_p_we(m0_we),
        .o_m0_p_rdy(a_rdy0), .o_m0_p_rdata(a_rd0),
        .i_m1_p_sel(m1_sel), .i_m1_p_strb(m1_strb), .i_m1_p_addr(m1_addr), .i_m1_p_wdata(m1_wdata), .i_m1_p_we(m1_we),
        .o_m1_p_rdy(a_rdy1), .o_m1_p_rdata(a_rd1),
        .o_p_sel(a_sel), .o_p_ce(a_ce), .o_p_we(a_we), .o_p_strb(a_strb), .o_p_addr(a_addr), .o_p_wdata(a_wdata),
        .i_p_rdy(p_rdy), .i_p_rdata(p_rdata), .o_timeout(a_to), .o_grant(a_gr)
    );

    ipsl_pcie_apb_arb_v1_0 #(.TO_W(16), .TO_CYCLES(16'd0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_p_sel(m0_sel), .i_m0_p_strb(m0_strb), .i_m0_p_addr(m0_addr), .i_m0_p_wdata(m0_wdata), .i_m0_p_we(m0_we),
        .o_m0_p_rdy(b_rdy0), .o_m0_p_rdata(b_rd0),
        .i_m1_p_sel(m1_sel), .i_m1_p_strb(m1_strb), .i_m1_p_addr(m1_addr), .i_m1_p_wdata(m1_wdata), .i_m1_p_we(m1_we),
        .o_m1_p_rdy(b_rdy1), .o_m1_p_rdata(b_rd1),
        .o_p_sel(b_sel), .o_p_ce(b_ce), .o_p_we(b_we), .o_p_strb(b_strb), .o_p_addr(b_addr), .o_p_wdata(b_wdata),
        .i_p_rdy(p_rdy), .i_p_rdata(p_rdata), .o_timeout(b_to), .o_grant(b_gr)
    );

    assign a_all  = {a_sel, a_ce, a_we, a_strb, a_addr, a_wdata, a_rdy0, a_rdy1, a_rd0, a_rd1, a_to, a_gr};
    assign b_all  = {b_sel, b_ce, b_we, b_strb, b_addr, b_wdata, b_rdy0, b_rdy1, b_rd0, b_rd1, b_to, b_gr};
    assign s_sel  = use_b ? b_sel  : a_sel;
    assign s_ce   = use_b ? b_ce   : a_ce;
    assign s_rdy0 = use_b ? b_rdy0 : a_rdy0;
    assign s_rdy1 = use_b ? b_rdy1 : a_rdy1;
    assign s_rd0  = use_b ? b_rd0  : a_rd0;
    assign s_rd1  = use_b ? b_rd1  : a_rd1;
    assign s_to   = use_b ? b_to   : a_to;
    assign s_gr   = use_b ? b_gr   : a_gr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: scoreboard on completions, then the slave model responds to the observed phase.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (s_rdy0 || s_rdy1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 128'({s_rdy1, s_rdy0}), 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdy_owner", 128'({s_rdy1, s_rdy0}), e.who ? 128'd2 : 128'd1);
                check("grant", 128'(s_gr), 128'(e.who));
                check("rdata", 128'(e.who ? s_rd1 : s_rd0), 128'(e.rdata));
                check("timeout_flag", 128'(s_to), 128'(e.to));
                check("done_cycle", 128'(cyc), 128'(e.cyc));
            end
            if (!hold && s_rdy0) m0_sel = 1'b0;
            if (!hold && s_rdy1) m1_sel = 1'b0;
        end else if (s_to) begin
            check("stray_timeout", 128'(s_to), 128'd0);
        end
        if (s_sel && !s_ce) begin
            wait_n = dly;
            p_rdy  = 1'b0;
        end else if (s_ce && !p_rdy && wait_n == 0) begin
            p_rdy   = 1'b1;
            p_rdata = rd_val;
        end else if (s_ce && !p_rdy) begin
            wait_n--;
        end else begin
            p_rdy = 1'b0;
        end
    endtask

    task automatic issue(input bit m, input bit we, input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        if (m) begin
            m1_sel = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_strb = strb;
        end else begin
            m0_sel = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_strb = strb;
        end
    endtask

    task automatic push(input bit who, input logic [31:0] rd, input bit to, input int c);
        exp_t e;
        e.who = who; e.rdata = rd; e.to = to; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_a", 128'(a_all), 128'd0);
        check("reset_b", 128'(b_all), 128'd0);
        rst_n = 1'b1;
        tick();
        tick();

        rd_val = 32'hA5A5_0001;
        dly    = 0;
        issue(1'b0, 1'b0, 16'h7004, 32'h0, 4'h0);
        push(1'b0, 32'hA5A5_0001, 1'b0, cyc + 3);
        tick();
        check("m0_setup", 128'({a_sel, a_ce}), 128'd2);
        check("m0_addr", 128'(a_addr), 128'h7004);
        tick();
        check("m0_access", 128'({a_sel, a_ce}), 128'd3);
        drain(20);
        tick();

        rd_val = 32'hDEAD_0002;
        dly    = 5;
        issue(1'b1, 1'b1, 16'h1010, 32'h1234_5678, 4'hF);
        push(1'b1, 32'hDEAD_0002, 1'b0, cyc + 8);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("m1_fields_stable", 128'({a_sel, a_we, a_strb, a_addr, a_wdata}), 128'({1'b1, 1'b1, 4'hF, 16'h1010, 32'h1234_5678}));
        end
        tick();
        check("m1_fields_cleared", 128'({a_sel, a_ce, a_we, a_strb, a_addr, a_wdata}), 128'd0);
        drain(5);
        tick();

        rd_val = 32'h0BAD_F00D;
        dly    = 0;
        hold   = 1'b1;
        issue(1'b0, 1'b0, 16'h0004, 32'h0, 4'h0);
        issue(1'b1, 1'b0, 16'h0008, 32'h0, 4'h0);
        push(1'b0, rd_val, 1'b0, cyc + 3);
        push(1'b1, rd_val, 1'b0, cyc + 7);
        push(1'b0, rd_val, 1'b0, cyc + 11);
        push(1'b1, rd_val, 1'b0, cyc + 15);
        drain(30);
        hold   = 1'b0;
        m0_sel = 1'b0;
        m1_sel = 1'b0;
        repeat (3) tick();
        check("rr_quiet", 128'(a_sel), 128'd0);

        dly = 1000000;
        issue(1'b0, 1'b0, 16'h0040, 32'h0, 4'h0);
        push(1'b0, 32'h0, 1'b1, cyc + 10);
        drain(30);
        tick();
        dly    = 0;
        rd_val = 32'h5555_AAAA;
        issue(1'b1, 1'b0, 16'h0044, 32'h0, 4'h0);
        push(1'b1, 32'h5555_AAAA, 1'b0, cyc + 3);
        drain(10);
        tick();

        dly = 10;
        issue(1'b0, 1'b1, 16'h0ABC, 32'h1, 4'h3);
        repeat (3) tick();
        check("rst_in_access", 128'({a_sel, a_ce}), 128'd3);
        #2 rst_n = 1'b0;
        #1 check("async_reset_a", 128'(a_all), 128'd0);
        check("async_reset_b", 128'(b_all), 128'd0);
        m0_sel = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        dly    = 0;
        rd_val = 32'h0000_1357;
        issue(1'b0, 1'b0, 16'h7004, 32'h0, 4'h0);
        push(1'b0, 32'h0000_1357, 1'b0, cyc + 3);
        drain(10);
        tick();

        use_b  = 1'b1;
        dly    = 3000;
        rd_val = 32'hCAFE_0005;
        issue(1'b0, 1'b0, 16'h0100, 32'h0, 4'h0);
        push(1'b0, 32'hCAFE_0005, 1'b0, cyc + 3003);
        drain(3100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
